packet_payload_capture: RTL and testbench

Downstream stage of the byte-stream packet detector. It takes the detector's header-found strobe and the same 8-bit byte stream, then parses a length byte, a payload and an optional XOR checksum. It emits the payload as a framed byte stream (valid/sof/eof) with a per-frame ok/err verdict. It consumes one byte per clock with no backpressure, matching the detector.

---
 rtl/pkt_pkg.sv | 24 ++
 rtl/pkt_xor_accum.sv | 30 +++
 rtl/packet_payload_capture.sv | 145 ++++++++++++++
 tb/tb_packet_payload_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet detector / payload capture pair:
// FSM state encoding, header byte constants and checksum seed.
package pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  // Header sequence recognised by the upstream detector.
  localparam logic [7:0] HDR_B0 = 8'hAA;
  localparam logic [7:0] HDR_B1 = 8'h55;
  localparam logic [7:0] HDR_B2 = 8'hF0;

  localparam logic [7:0] CHK_INIT = 8'h00;

  // A length is usable only if it is non-zero and fits the capture window.
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'h00) && (len <= max_len);
  endfunction

endpackage

// File: rtl/pkt_xor_accum.sv
// 8-bit XOR accumulator with synchronous load/enable and an equality
// compare against an external byte.
module pkt_xor_accum
  import pkt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] cmp_val,
  output logic       match
);

  logic [7:0] acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= CHK_INIT;
    end else if (load) begin
      acc_reg <= load_val;
    end else if (en) begin
      acc_reg <= acc_reg ^ din;
    end
  end

  assign match = (acc_reg == cmp_val);

endmodule

// File: rtl/packet_payload_capture.sv
// Parses length, payload and optional XOR checksum after the detector's header strobe.
// Checksum stage is built only when PKT_CAPTURE_CHECKSUM_EN is defined.
module packet_payload_capture
  import pkt_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  input  logic       hdr_det,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] state
);

  localparam int              CW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          first_reg, first_next;
  logic [7:0]    out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;
  logic          out_sof_reg, out_sof_next;
  logic          out_eof_reg, out_eof_next;
  logic          frame_ok_reg, frame_ok_next;
  logic          frame_err_reg, frame_err_next;

`ifdef PKT_CAPTURE_CHECKSUM_EN
  logic acc_load, acc_en, acc_match;

  // The checksum byte is compared straight off the bus while in CHK.
  pkt_xor_accum u_accum (
    .clk      (clk),
    .reset    (reset),
    .load     (acc_load),
    .load_val (X),
    .en       (acc_en),
    .din      (X),
    .cmp_val  (X),
    .match    (acc_match)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      first_reg     <= 1'b0;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      first_reg     <= first_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_sof_reg   <= out_sof_next;
      out_eof_reg   <= out_eof_next;
      frame_ok_reg  <= frame_ok_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    first_next     = first_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    out_sof_next   = 1'b0;
    out_eof_next   = 1'b0;
    frame_ok_next  = 1'b0;
    frame_err_next = 1'b0;
`ifdef PKT_CAPTURE_CHECKSUM_EN
    acc_load       = 1'b0;
    acc_en         = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (hdr_det) state_next = ST_LEN;
      end
      ST_LEN: begin
        // Range check happens before the counter load, so the counter never wraps.
        if (!len_ok(X, MAX_LEN_B)) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          cnt_next   = X[CW-1:0];
          first_next = 1'b1;
          state_next = ST_PAYLOAD;
`ifdef PKT_CAPTURE_CHECKSUM_EN
          acc_load   = 1'b1;
`endif
        end
      end
      ST_PAYLOAD: begin
        out_data_next  = X;
        out_valid_next = 1'b1;
        out_sof_next   = first_reg;
        first_next     = 1'b0;
        cnt_next       = cnt_reg - CNT_ONE;
`ifdef PKT_CAPTURE_CHECKSUM_EN
        acc_en         = 1'b1;
`endif
        if (cnt_reg == CNT_ONE) begin
          out_eof_next = 1'b1;
`ifdef PKT_CAPTURE_CHECKSUM_EN
          state_next   = ST_CHK;
`else
          frame_ok_next = 1'b1;
          state_next    = ST_IDLE;
`endif
        end
      end
`ifdef PKT_CAPTURE_CHECKSUM_EN
      ST_CHK: begin
        frame_ok_next  = acc_match;
        frame_err_next = !acc_match;
        state_next     = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign out_eof   = out_eof_reg;
  assign frame_ok  = frame_ok_reg;
  assign frame_err = frame_err_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_packet_payload_capture.sv
// Self-checking bench for packet_payload_capture: frame-level schedule builder
// produces per-cycle stimulus and expected outputs; one process compares every cycle.
module tb_packet_payload_capture;

  localparam int N      = 160;
  localparam int MAXLEN = 16;

  logic       clk = 1'b1;
  logic       reset;
  logic [7:0] X;
  logic       hdr_det;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eof, frame_ok, frame_err;
  logic [1:0] state;

  packet_payload_capture #(.MAX_LEN(MAXLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .hdr_det   (hdr_det),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Index c: inputs sampled at rising edge c, expected outputs right after edge c.
  logic [7:0] x_vec   [N];
  logic       hdr_vec [N];
  logic       rst_vec [N];
  logic [7:0] e_data  [N];
  logic       e_valid [N];
  logic       e_sof   [N];
  logic       e_eof   [N];
  logic       e_ok    [N];
  logic       e_err   [N];
  logic [1:0] e_state [N];
  int cur;
  int checks = 0;
  int passes = 0;

  function automatic void idle(input int k);
    cur = cur + k;
  endfunction

  // Lays out one frame starting with the header strobe at cycle cur.
  // pl holds payload bytes, first byte in [7:0]; abort_after>=0 resets after that many bytes.
  function automatic void add_frame(input logic [7:0] len, input logic [31:0] pl,
                                    input logic [7:0] chk, input bit mid_hdr,
                                    input int abort_after);
    logic [7:0] acc;
    logic [7:0] b;
    int t;
    int n;
    t = cur;
    hdr_vec[t] = 1'b1;
    e_state[t] = 2'd1;
    x_vec[t+1] = len;
    if (len == 8'h00 || int'(len) > MAXLEN) begin
      e_err[t+1]   = 1'b1;
      e_state[t+1] = 2'd0;
      cur = t + 2;
      return;
    end
    e_state[t+1] = 2'd2;
    acc = len;
    n = (abort_after >= 0) ? abort_after : int'(len);
    for (int i = 0; i < n; i++) begin
      b = pl[8*i +: 8];
      x_vec[t+2+i]   = b;
      hdr_vec[t+2+i] = mid_hdr;
      acc = acc ^ b;
      e_valid[t+2+i] = 1'b1;
      e_data[t+2+i]  = b;
      e_sof[t+2+i]   = (i == 0);
      e_eof[t+2+i]   = (i == int'(len) - 1);
`ifdef PKT_CAPTURE_CHECKSUM_EN
      e_state[t+2+i] = (i == int'(len) - 1) ? 2'd3 : 2'd2;
`else
      e_state[t+2+i] = (i == int'(len) - 1) ? 2'd0 : 2'd2;
`endif
    end
    if (abort_after >= 0) begin
      rst_vec[t+2+n] = 1'b0;
      rst_vec[t+3+n] = 1'b0;
      cur = t + 4 + n;
      return;
    end
`ifdef PKT_CAPTURE_CHECKSUM_EN
    x_vec[t+2+n]   = chk;
    e_ok[t+2+n]    = (chk == acc);
    e_err[t+2+n]   = (chk != acc);
    e_state[t+2+n] = 2'd0;
    cur = t + 3 + n;
`else
    e_ok[t+1+n] = 1'b1;
    cur = t + 2 + n;
`endif
  endfunction

  initial begin
    for (int c = 0; c < N; c++) begin
      x_vec[c] = 8'hAA; hdr_vec[c] = 1'b0; rst_vec[c] = 1'b1;
      e_data[c] = 8'h00; e_valid[c] = 1'b0; e_sof[c] = 1'b0; e_eof[c] = 1'b0;
      e_ok[c] = 1'b0; e_err[c] = 1'b0; e_state[c] = 2'd0;
    end
    rst_vec[0] = 1'b0;
    rst_vec[1] = 1'b0;
    cur = 3;
    add_frame(8'h03, 32'h0033_2211, 8'h03, 1'b0, -1);   // nominal, hdr at 3
    idle(2);
    add_frame(8'h03, 32'h0033_2211, 8'h04, 1'b0, -1);   // bad checksum
    idle(1);
    add_frame(8'h00, 32'h0, 8'h00, 1'b0, -1);           // L=0
    add_frame(8'h11, 32'h0, 8'h00, 1'b0, -1);           // L=17
    idle(1);
    add_frame(8'h04, 32'h00F0_55AA, 8'h0B, 1'b1, -1);   // embedded header bytes
    add_frame(8'h01, 32'h0000_007E, 8'h7F, 1'b0, -1);   // L=1, zero gap
    idle(2);
    add_frame(8'h02, 32'h0000_2010, 8'h32, 1'b0, -1);   // back-to-back pair
    add_frame(8'h01, 32'h0000_005A, 8'h5B, 1'b0, -1);
    idle(2);
    add_frame(8'h05, 32'h4433_2211, 8'h00, 1'b0, 2);    // reset after 2 of 5 bytes
    idle(1);
    add_frame(8'h02, 32'h0000_3CC3, 8'hFD, 1'b0, -1);   // recovery frame
  end

  // Driver: apply cycle c's inputs on the falling edge before rising edge c.
  initial begin
    reset   = 1'b0;
    X       = 8'h00;
    hdr_det = 1'b0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      reset   = rst_vec[c];
      hdr_det = hdr_vec[c];
      X       = x_vec[c];
      if (c > 2 && !rst_vec[c] && rst_vec[c-1]) begin
        #1;
        checks++;
        if ({out_data, out_valid, out_sof, out_eof, frame_ok, frame_err, state} == 15'd0)
          passes++;
        else
          $display("FAIL async_reset cyc%0d got data=%h v=%b sof=%b eof=%b ok=%b err=%b st=%0d expected all zero",
                   c, out_data, out_valid, out_sof, out_eof, frame_ok, frame_err, state);
      end
    end
  end

  task automatic pin(input string name, input int c, input logic ok_cond,
                     input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (ok_cond) passes++;
    else $display("FAIL pin_%s cyc%0d got %h expected %h", name, c, got, want);
  endtask

  // Compare process: every cycle against the schedule, plus hand-computed pins.
  initial begin
    logic [15:0] act, exp_v;
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      act   = {out_valid ? out_data : 8'h00, out_valid, out_sof & out_valid,
               out_eof & out_valid, frame_ok, frame_err, state};
      exp_v = {e_data[c], e_valid[c], e_sof[c], e_eof[c], e_ok[c], e_err[c], e_state[c]};
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL cycle%0d got data=%h v=%b sof=%b eof=%b ok=%b err=%b st=%0d expected data=%h v=%b sof=%b eof=%b ok=%b err=%b st=%0d",
                    c, act[15:8], act[7], act[6], act[5], act[4], act[3], act[1:0],
                    exp_v[15:8], exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3], exp_v[1:0]);
      // First frame: hdr at 3, length at 4, payload 11/22/33 at 5..7.
      if (c == 5) pin("first_byte", c, out_valid && out_sof && out_data == 8'h11, out_data, 8'h11);
      if (c == 6) pin("mid_byte", c, out_valid && !out_sof && !out_eof && out_data == 8'h22, out_data, 8'h22);
      if (c == 7) pin("last_byte", c, out_valid && out_eof && out_data == 8'h33, out_data, 8'h33);
`ifdef PKT_CAPTURE_CHECKSUM_EN
      if (c == 8) pin("frame_ok", c, frame_ok && !frame_err && !out_valid, {7'd0, frame_ok}, 8'h01);
`else
      if (c == 7) pin("frame_ok", c, frame_ok && !frame_err, {7'd0, frame_ok}, 8'h01);
`endif
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
